// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it. Frames are start bit,
// DATA_BITS data bits LSB first, then STOP_BITS stop bits, one bit per baud_tick.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  // Transmitter state
  state_e               state_q;
  state_e               state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [BW-1:0]        bit_cnt_q;
  logic [BW-1:0]        bit_cnt_d;
  logic                 stop_cnt_q;
  logic                 stop_cnt_d;
  logic                 tx_q;
  logic                 tx_d;

  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign push       = tx_valid && tx_ready;

  // NOTE: the storage array carries no reset; only the pointers and count need
  // one, and leaving the data unreset lets it map onto plain RAM/flops without
  // a reset network. Stale entries are never visible because count gates reads.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State register together with the registered serial datapath
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state and next-datapath logic; nothing moves without a tick
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d = 1'b1;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        STOP: begin
          if (stop_cnt_q != LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            tx_d       = 1'b1;
          end else if (pop) begin
            // Back-to-back frame: next start bit follows the last stop bit
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pop = 1'b0;
    if (baud_tick && !fifo_empty) begin
      pop = (state_q == IDLE) || ((state_q == STOP) && (stop_cnt_q == LAST_STOP));
    end
    tx_ready   = (count_q < FULL_CNT);
    busy       = (state_q != IDLE) || !fifo_empty;
    fifo_count = count_q;
    tx         = tx_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: one- and two-stop-bit instances driven in lockstep and
// compared every cycle against a frame-level model, plus directed scenario checks.
module tb_uart_tx_fifo;

  logic       clk_in;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       tx_w       [2];
  logic       ready_w    [2];
  logic       busy_w     [2];
  logic [2:0] cnt_w      [2];

  int nvec;
  int nerr;

  // Reference model state, one set per instance (index 0: 1 stop bit, 1: 2 stop bits)
  logic [7:0]  m_mem    [2][4];
  int          m_head   [2];
  int          m_cnt    [2];
  int          m_left   [2];
  logic [15:0] m_frame  [2];
  logic        m_tx     [2];
  logic        m_active [2];

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .fifo_count(cnt_w[0])
  );

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .fifo_count(cnt_w[1])
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic int stop_bits(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic model_reset(input int i);
    m_head[i]   = 0;
    m_cnt[i]    = 0;
    m_left[i]   = 0;
    m_frame[i]  = '0;
    m_tx[i]     = 1'b1;
    m_active[i] = 1'b0;
  endtask

  // One clock of the spec's rules: line advances one bit per tick, FIFO pop
  // only from entries present at the start of the cycle, push when not full.
  task automatic model_update(input int i, input logic v, input logic [7:0] d, input logic t);
    int old_cnt;
    int tail;
    logic acc;
    old_cnt = m_cnt[i];
    tail    = (m_head[i] + old_cnt) % 4;
    acc     = v && (old_cnt < 4);
    if (t) begin
      if (m_left[i] > 0) begin
        m_tx[i]    = m_frame[i][0];
        m_frame[i] = m_frame[i] >> 1;
        m_left[i]  = m_left[i] - 1;
      end else if (old_cnt > 0) begin
        m_frame[i]      = 16'hFFFF;
        m_frame[i][8:1] = m_mem[i][m_head[i]];
        m_frame[i][0]   = 1'b0;
        m_head[i]       = (m_head[i] + 1) % 4;
        m_cnt[i]        = m_cnt[i] - 1;
        m_tx[i]         = m_frame[i][0];
        m_frame[i]      = m_frame[i] >> 1;
        m_left[i]       = 8 + stop_bits(i);
        m_active[i]     = 1'b1;
      end else begin
        m_tx[i]     = 1'b1;
        m_active[i] = 1'b0;
      end
    end
    if (acc) begin
      m_mem[i][tail] = d;
      m_cnt[i]       = m_cnt[i] + 1;
    end
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (tx_w[i] !== m_tx[i]) begin
        nerr++;
        $display("FAIL %s dut%0d tx: got %b expected %b at %0t", tag, i, tx_w[i], m_tx[i], $time);
      end
      nvec++;
      if (cnt_w[i] !== 3'(m_cnt[i])) begin
        nerr++;
        $display("FAIL %s dut%0d fifo_count: got %0d expected %0d at %0t", tag, i, cnt_w[i], m_cnt[i], $time);
      end
      nvec++;
      if (ready_w[i] !== (m_cnt[i] < 4)) begin
        nerr++;
        $display("FAIL %s dut%0d tx_ready: got %b expected %b at %0t", tag, i, ready_w[i], (m_cnt[i] < 4), $time);
      end
      nvec++;
      if (busy_w[i] !== (m_active[i] || (m_cnt[i] > 0))) begin
        nerr++;
        $display("FAIL %s dut%0d busy: got %b expected %b at %0t", tag, i, busy_w[i],
                 (m_active[i] || (m_cnt[i] > 0)), $time);
      end
    end
  endtask

  // Drive one cycle from a falling edge, advance the model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic t, input string tag);
    tx_valid  = v;
    tx_data   = d;
    baud_tick = t;
    @(posedge clk_in);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else        model_update(i, v, d, t);
    end
    @(negedge clk_in);
    compare_model(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, tag);
  endtask

  // n ticks, one every `period` cycles; bits[k] is dut1's tx right after tick k
  task automatic run_ticks(input int n, input int period, input string tag, output logic [31:0] bits);
    bits = '0;
    for (int k = 0; k < n; k++) begin
      idle_cycles(period - 1, tag);
      step(1'b0, 8'h00, 1'b1, tag);
      if (k < 32) bits[k] = tx_w[0];
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b1, 8'hA7, 1'b0, "reset");
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (tx_w[i] !== 1'b1 || ready_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || cnt_w[i] !== 3'd0) begin
        nerr++;
        $display("FAIL reset_values dut%0d: got tx=%b ready=%b busy=%b count=%0d expected 1 1 0 0",
                 i, tx_w[i], ready_w[i], busy_w[i], cnt_w[i]);
      end
    end
    rst_n = 1'b1;
    idle_cycles(3, "reset_release");
    nvec++;
    if (cnt_w[0] !== 3'd0) begin
      nerr++;
      $display("FAIL reset_no_push: got fifo_count=%0d expected 0", cnt_w[0]);
    end
  endtask

  task automatic test_single_byte;
    logic [31:0] bits;
    logic [9:0]  expect_bits;
    step(1'b1, 8'h55, 1'b0, "single_push");
    nvec++;
    if (busy_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL single_busy_rise: got %b expected 1", busy_w[0]);
    end
    run_ticks(10, 16, "single", bits);
    expect_bits = {1'b1, 8'h55, 1'b0};
    nvec++;
    if (bits[9:0] !== expect_bits) begin
      nerr++;
      $display("FAIL single_frame: got %b expected %b (bit0 first on right)", bits[9:0], expect_bits);
    end
    nvec++;
    if (busy_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL single_busy_stop: got %b expected 1 during stop bit", busy_w[0]);
    end
    run_ticks(1, 16, "single_end", bits);
    nvec++;
    if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL single_busy_fall: got busy=%b tx=%b expected 0 1", busy_w[0], tx_w[0]);
    end
    run_ticks(2, 16, "single_tail", bits);
  endtask

  task automatic test_back_to_back;
    logic [31:0] bits;
    logic [19:0] expect_bits;
    step(1'b1, 8'hA5, 1'b0, "b2b_push");
    step(1'b1, 8'h3C, 1'b0, "b2b_push");
    run_ticks(20, 16, "b2b", bits);
    expect_bits = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    nvec++;
    if (bits[19:0] !== expect_bits) begin
      nerr++;
      $display("FAIL b2b_frames: got %b expected %b", bits[19:0], expect_bits);
    end
    run_ticks(6, 16, "b2b_tail", bits);
  endtask

  task automatic test_fifo_full;
    logic [31:0] bits;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 8'(k), 1'b0, "full_push");
      if (k == 3) begin
        nvec++;
        if (ready_w[0] !== 1'b1) begin
          nerr++;
          $display("FAIL full_ready_early: got %b expected 1 after 3 pushes", ready_w[0]);
        end
      end
    end
    nvec++;
    if (ready_w[0] !== 1'b0 || cnt_w[0] !== 3'd4) begin
      nerr++;
      $display("FAIL full_state: got ready=%b count=%0d expected 0 4", ready_w[0], cnt_w[0]);
    end
    run_ticks(1, 4, "full_pop", bits);
    nvec++;
    if (ready_w[0] !== 1'b1 || cnt_w[0] !== 3'd3) begin
      nerr++;
      $display("FAIL full_pop_ready: got ready=%b count=%0d expected 1 3", ready_w[0], cnt_w[0]);
    end
    run_ticks(50, 4, "full_drain", bits);
    nvec++;
    if (busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) begin
      nerr++;
      $display("FAIL full_drained: got busy=%b/%b expected 0/0", busy_w[0], busy_w[1]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] bits;
    step(1'b1, 8'hFF, 1'b0, "midrst_push");
    step(1'b1, 8'h12, 1'b0, "midrst_push");
    step(1'b1, 8'h34, 1'b0, "midrst_push");
    run_ticks(5, 8, "midrst_run", bits);
    idle_cycles(3, "midrst_run");
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (tx_w[i] !== 1'b1 || cnt_w[i] !== 3'd0 || busy_w[i] !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_async dut%0d: got tx=%b count=%0d busy=%b expected 1 0 0",
                 i, tx_w[i], cnt_w[i], busy_w[i]);
      end
    end
    @(negedge clk_in);
    step(1'b1, 8'h99, 1'b1, "midrst_hold");
    step(1'b0, 8'h00, 1'b0, "midrst_hold");
    rst_n = 1'b1;
    run_ticks(15, 8, "midrst_quiet", bits);
    nvec++;
    if (bits[14:0] !== 15'h7FFF) begin
      nerr++;
      $display("FAIL midrst_quiet_line: got %b expected all ones", bits[14:0]);
    end
  endtask

  task automatic test_stop_bits2;
    logic [31:0] bits2;
    logic [21:0] line2;
    logic [21:0] expect_bits;
    step(1'b1, 8'h00, 1'b0, "stop2_push");
    step(1'b1, 8'hC3, 1'b0, "stop2_push");
    line2 = '0;
    for (int k = 0; k < 22; k++) begin
      idle_cycles(9, "stop2");
      step(1'b0, 8'h00, 1'b1, "stop2");
      line2[k] = tx_w[1];
    end
    expect_bits = {2'b11, 8'hC3, 1'b0, 2'b11, 8'h00, 1'b0};
    nvec++;
    if (line2 !== expect_bits) begin
      nerr++;
      $display("FAIL stop2_frames: got %b expected %b", line2, expect_bits);
    end
    run_ticks(4, 10, "stop2_tail", bits2);
  endtask

  task automatic test_random;
    logic prev_t;
    logic t;
    logic v;
    prev_t = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      t = !prev_t && ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 9) < ((k / 500) % 2 == 0 ? 2 : 7));
      step(v, 8'($urandom), t, "random");
      prev_t = t;
    end
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    baud_tick = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    for (int i = 0; i < 2; i++) model_reset(i);
    @(negedge clk_in);
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_fifo_full;
    test_reset_mid_frame;
    test_stop_bits2;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
